// File: rtl/out_tx_fifo.sv
// Output-side FIFO and serializer for OUT results. Each 16-bit word is sent
// as two 8N1 frames on tx, low byte first, with no gap between the two frames.
module out_tx_fifo #(
  parameter int DEPTH        = 4,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      wr_en,
  input  logic [15:0]               wr_data,
  output logic                      tx,
  output logic                      busy,
  output logic                      full,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam logic [AW:0]   DEPTH_C  = (AW + 1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [TW-1:0] BIT_LAST = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] TMR_ONE  = TW'(1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic [15:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [15:0]   head;
  logic          wr_ok;
  logic          pop;

  state_t        state;
  logic [TW-1:0] timer;
  logic [2:0]    bit_idx;
  logic          byte_idx;
  logic          bit_end;
  logic [7:0]    shift;
  logic [7:0]    hold_hi;

  assign full    = (count == DEPTH_C);
  assign head    = mem[rd_ptr];
  assign wr_ok   = wr_en && !full;
  assign pop     = (state == IDLE) && (count != '0);
  assign bit_end = (timer == BIT_LAST);

  // FIFO storage: contents are don't-care while count is zero
  always_ff @(posedge clock) begin
    if (wr_ok) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // FIFO control: a write seen while full is lost even if a pop frees a slot
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_ok) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      if (wr_en && full) begin
        overflow <= 1'b1;
      end
      case ({wr_ok, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Serializer datapath: holds the in-flight word, no reset needed
  always_ff @(posedge clock) begin
    if (pop) begin
      hold_hi <= head[15:8];
      shift   <= head[7:0];
    end else if (state == DATA && bit_end && bit_idx != 3'd7) begin
      shift <= {1'b0, shift[7:1]};
    end else if (state == STOP && bit_end && !byte_idx) begin
      shift <= hold_hi;
    end
  end

  // Serializer FSM: tx and busy are registered alongside the state
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      timer    <= '0;
      bit_idx  <= '0;
      byte_idx <= 1'b0;
      tx       <= 1'b1;
      busy     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          timer <= '0;
          tx    <= 1'b1;
          busy  <= 1'b0;
          if (pop) begin
            state    <= START;
            byte_idx <= 1'b0;
            tx       <= 1'b0;
            busy     <= 1'b1;
          end
        end
        START: begin
          if (bit_end) begin
            state   <= DATA;
            timer   <= '0;
            bit_idx <= '0;
            tx      <= shift[0];
          end else begin
            timer <= timer + TMR_ONE;
          end
        end
        DATA: begin
          if (bit_end) begin
            timer <= '0;
            if (bit_idx == 3'd7) begin
              state <= STOP;
              tx    <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              tx      <= shift[1];
            end
          end else begin
            timer <= timer + TMR_ONE;
          end
        end
        STOP: begin
          if (bit_end) begin
            timer <= '0;
            if (!byte_idx) begin
              // high byte follows immediately, without passing through IDLE
              byte_idx <= 1'b1;
              state    <= START;
              tx       <= 1'b0;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            timer <= timer + TMR_ONE;
          end
        end
        default: begin
          state <= IDLE;
          timer <= '0;
          tx    <= 1'b1;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_out_tx_fifo.sv
// Bench for out_tx_fifo: scenario tasks plus a line receiver that decodes tx
// and checks each received word against a queue of expected words.
module tb_out_tx_fifo;

  localparam int DEPTH = 4;
  localparam int CPB   = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          wr_en = 1'b0;
  logic [15:0]   wr_data = 16'h0000;
  logic          tx;
  logic          busy;
  logic          full;
  logic [CW-1:0] count;
  logic          overflow;

  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  int          rx_words = 0;
  logic [15:0] exp_q[$];
  int          start_q[$];

  out_tx_fifo #(.DEPTH(DEPTH), .CLKS_PER_BIT(CPB)) dut (
    .clock    (clock),
    .reset    (reset),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .tx       (tx),
    .busy     (busy),
    .full     (full),
    .count    (count),
    .overflow (overflow)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Line receiver: checks every cycle of every bit, then scores the word
  initial begin : monitor
    logic        prev;
    logic        act;
    logic        bitv;
    logic        lvl;
    logic [15:0] w;
    logic [15:0] e;
    int          n;
    int          b;
    int          ph;
    prev = 1'b1;
    act  = 1'b0;
    bitv = 1'b0;
    w    = '0;
    n    = 0;
    forever begin
      @(negedge clock);
      if (reset) begin
        act  = 1'b0;
        prev = 1'b1;
      end else begin
        if (!act && prev && !tx) begin
          act = 1'b1;
          n   = 0;
          w   = '0;
          start_q.push_back(cyc);
        end
        if (act) begin
          b  = n / CPB;
          ph = n % CPB;
          if (b == 0 || b == 10)      lvl = 1'b0;
          else if (b == 9 || b == 19) lvl = 1'b1;
          else                        lvl = bitv;
          if (b != 0 && b != 9 && b != 10 && b != 19 && ph == 0) begin
            bitv = tx;
            if (b < 9) w[b-1] = tx;
            else       w[b-3] = tx;
          end else begin
            tests++;
            if (tx !== lvl) begin
              fails++;
              $display("FAIL rx_line word%0d bit%0d phase%0d: tx=%b, expected %b", rx_words, b, ph, tx, lvl);
            end
          end
          n++;
          if (n == 20 * CPB) begin
            act = 1'b0;
            rx_words++;
            tests++;
            if (exp_q.size() == 0) begin
              fails++;
              $display("FAIL rx_word: received %h, expected no word", w);
            end else begin
              e = exp_q.pop_front();
              if (w !== e) begin
                fails++;
                $display("FAIL rx_word: received %h, expected %h", w, e);
              end
            end
          end
        end
        prev = tx;
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, tests=%0d fails=%0d", tests, fails + 1);
    $fatal(1, "watchdog");
  end

  task automatic step;
    @(posedge clock);
    #1;
  endtask

  task automatic write_word(input logic [15:0] d);
    wr_en   = 1'b1;
    wr_data = d;
    step;
    wr_en   = 1'b0;
  endtask

  task automatic wait_idle(input int limit, input string tag);
    int k;
    k = 0;
    while (!(busy === 1'b0 && count === '0) && k < limit) begin
      step;
      k++;
    end
    tests++;
    if (k >= limit) begin
      fails++;
      $display("FAIL %s_timeout: busy=%b count=%0d after %0d cycles, expected idle", tag, busy, count, k);
    end
    step;
    step;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) step;
    reset = 1'b0;
    for (int i = 0; i < 50; i++) begin
      step;
      tests++;
      if ({tx, busy, full, overflow, count} !== {1'b1, 1'b0, 1'b0, 1'b0, CW'(0)}) begin
        fails++;
        $display("FAIL reset_idle cyc%0d: tx=%b busy=%b full=%b ovf=%b count=%0d, expected 1 0 0 0 0",
                 i, tx, busy, full, overflow, count);
      end
    end
  endtask

  task automatic test_frame;
    logic [19:0] stream;
    int          busy_cycles;
    stream      = 20'b00101101010101001011;
    busy_cycles = 0;
    exp_q.push_back(16'hA55A);
    write_word(16'hA55A);
    tests++;
    if (tx !== 1'b1 || count !== CW'(1)) begin
      fails++;
      $display("FAIL frame_accept: tx=%b count=%0d, expected tx=1 count=1", tx, count);
    end
    step;
    tests++;
    if (tx !== 1'b0 || busy !== 1'b1 || count !== CW'(0)) begin
      fails++;
      $display("FAIL frame_pop: tx=%b busy=%b count=%0d, expected 0 1 0", tx, busy, count);
    end
    for (int i = 0; i < 20 * CPB; i++) begin
      tests++;
      if (tx !== stream[19 - (i / CPB)]) begin
        fails++;
        $display("FAIL frame_stream cyc%0d: tx=%b, expected %b", i, tx, stream[19 - (i / CPB)]);
      end
      if (busy === 1'b1) busy_cycles++;
      step;
    end
    tests++;
    if (busy_cycles != 20 * CPB || busy !== 1'b0 || tx !== 1'b1) begin
      fails++;
      $display("FAIL frame_busy: busy_cycles=%0d busy=%b tx=%b, expected %0d 0 1", busy_cycles, busy, tx, 20 * CPB);
    end
    wait_idle(20, "frame");
  endtask

  task automatic test_overflow;
    int   exp_cnt [6] = '{1, 1, 2, 3, 4, 4};
    logic exp_full[6] = '{0, 0, 0, 0, 1, 1};
    logic exp_ovf [6] = '{0, 0, 0, 0, 0, 1};
    for (int i = 1; i <= 6; i++) begin
      wr_en   = 1'b1;
      wr_data = 16'(i);
      if (i <= 5) exp_q.push_back(16'(i));
      step;
      tests++;
      if (count !== CW'(exp_cnt[i-1]) || full !== exp_full[i-1] || overflow !== exp_ovf[i-1]) begin
        fails++;
        $display("FAIL ovf_write%0d: count=%0d full=%b ovf=%b, expected %0d %b %b",
                 i, count, full, overflow, exp_cnt[i-1], exp_full[i-1], exp_ovf[i-1]);
      end
      if (i == 2) begin
        tests++;
        if (busy !== 1'b1) begin
          fails++;
          $display("FAIL ovf_first_pop: busy=%b, expected 1", busy);
        end
      end
    end
    wr_en = 1'b0;
    wait_idle(6 * 20 * CPB + 50, "ovf_drain");
    tests++;
    if (overflow !== 1'b1 || count !== CW'(0)) begin
      fails++;
      $display("FAIL ovf_sticky: ovf=%b count=%0d, expected 1 0", overflow, count);
    end
  endtask

  task automatic test_back_to_back;
    start_q.delete();
    exp_q.push_back(16'h1234);
    write_word(16'h1234);
    step;
    step;
    exp_q.push_back(16'hBEEF);
    write_word(16'hBEEF);
    wait_idle(3 * 20 * CPB, "b2b");
    tests++;
    if (start_q.size() != 2) begin
      fails++;
      $display("FAIL b2b_starts: saw %0d frame starts, expected 2", start_q.size());
    end else if (start_q[1] - start_q[0] != 20 * CPB + 1) begin
      fails++;
      $display("FAIL b2b_spacing: %0d cycles, expected %0d", start_q[1] - start_q[0], 20 * CPB + 1);
    end
  endtask

  task automatic test_reset_mid;
    wr_en = 1'b1;
    wr_data = 16'h1111;
    step;
    wr_data = 16'h2222;
    step;
    wr_data = 16'h3333;
    step;
    wr_en = 1'b0;
    tests++;
    if (count !== CW'(2) || busy !== 1'b1) begin
      fails++;
      $display("FAIL rst_mid_queued: count=%0d busy=%b, expected 2 1", count, busy);
    end
    repeat (53) step;
    reset = 1'b1;
    #1;
    tests++;
    if (tx !== 1'b1 || busy !== 1'b0 || count !== CW'(0)) begin
      fails++;
      $display("FAIL rst_mid_async: tx=%b busy=%b count=%0d, expected 1 0 0", tx, busy, count);
    end
    @(posedge clock);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step;
      tests++;
      if ({tx, busy, full, overflow, count} !== {1'b1, 1'b0, 1'b0, 1'b0, CW'(0)}) begin
        fails++;
        $display("FAIL rst_mid_after cyc%0d: tx=%b busy=%b full=%b ovf=%b count=%0d, expected 1 0 0 0 0",
                 i, tx, busy, full, overflow, count);
      end
    end
    exp_q.push_back(16'h00FF);
    write_word(16'h00FF);
    wait_idle(2 * 20 * CPB, "rst_mid_new");
  endtask

  task automatic test_wrap;
    int          rx0;
    logic [15:0] d;
    rx0 = rx_words;
    for (int i = 0; i < 10; i++) begin
      d = 16'($urandom);
      exp_q.push_back(d);
      write_word(d);
      wait_idle(20 * CPB + 20, "wrap");
    end
    tests++;
    if (rx_words - rx0 != 10 || overflow !== 1'b0 || exp_q.size() != 0) begin
      fails++;
      $display("FAIL wrap: received=%0d ovf=%b pending=%0d, expected 10 0 0", rx_words - rx0, overflow, exp_q.size());
    end
  endtask

  initial begin : main
    test_reset;
    test_frame;
    test_overflow;
    test_back_to_back;
    test_reset_mid;
    test_wrap;
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_empty: %0d words never received, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/out_tx_fifo.md
# out_tx_fifo

Output-side peripheral that consumes the 16-bit values produced by the controller's OUT instruction. Each OUT result is strobed into a small FIFO and then transmitted on a single serial line as two 8N1 UART-style frames, low byte first. The block sits directly downstream of the controller's `result` register. It decouples instruction execution from the slow serial link and flags any words lost to overflow.

## Interface
Parameters:
- `DEPTH`, 4: FIFO depth in 16-bit words; must be a power of two, ≥2.
- `CLKS_PER_BIT`, 16: clock cycles per serial bit; must be ≥2.

Ports:
- `clock`  in  1: single clock, all state updates on its rising edge.
- `reset`  in  1: asynchronous, active-high; clears all state.
- `wr_en`  in  1: one-cycle write strobe, asserted by the controller when OUT completes.
- `wr_data`  in  16: word to enqueue; sampled on the edge where `wr_en`=1.
- `tx`  out  1: serial output, idle high.
- `busy`  out  1: 1 whenever the serializer is not in IDLE.
- `full`  out  1: 1 when `count`==`DEPTH`.
- `count`  out  clog2(DEPTH)+1: number of words currently held in the FIFO, excluding the word being shifted.
- `overflow`  out  1: sticky; set when a write is dropped.

## Operation
- FIFO:
  - Circular buffer with read/write pointers of clog2(DEPTH) bits that wrap modulo DEPTH.
  - A write is accepted when `wr_en`=1 and `full`=0 as registered before the edge.
  - A write with `full`=1 is dropped, even if a pop happens on the same edge, and sets `overflow`=1.
  - `overflow` clears only on reset.
  - A simultaneous accepted write and pop leaves `count` unchanged.
- Serializer FSM states: IDLE, START, DATA, STOP.
  - IDLE: `tx`=1. If `count`≠0, on the next edge pop the head word into a 16-bit holding register, load the low byte into the shift register, set byte index to 0, go to START.
  - START: `tx`=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: `tx` = shift[0]. Every CLKS_PER_BIT cycles, shift right and increment the bit index. After bit 7 completes, go to STOP.
  - STOP: `tx`=1 for CLKS_PER_BIT cycles. Then:
    - If byte index is 0: load the high byte, set byte index to 1, go to START directly with no idle gap.
    - Otherwise: go to IDLE.
- Bit timer:
  - Counts 0..CLKS_PER_BIT-1.
  - Resets to 0 on every state or bit transition.
  - Each bit is exactly CLKS_PER_BIT cycles.
- `tx` is driven from a register; no combinational path from `wr_en` to `tx`.

## Timing
- Reset values: `tx`=1, `busy`=0, `full`=0, `count`=0, `overflow`=0, FSM=IDLE, both pointers=0.
- Reset asserted mid-frame: `tx` goes to 1 immediately (asynchronous), the FIFO is emptied, and the in-flight word is discarded.
- Latency: a write accepted at edge N into an empty, idle block gives a pop at edge N+1, with `tx` falling and `busy` rising after edge N+1.
- One word = 20·CLKS_PER_BIT cycles of `busy`=1, followed by at least one IDLE cycle with `tx`=1.
- Back-to-back words: consecutive `tx` falling edges are 20·CLKS_PER_BIT+1 cycles apart.
- `count` and `full` update on the edge of the write or pop; `full` is derived combinationally from the registered `count`.
- Writes are legal on every cycle, including while the serializer is busy.

## Test plan
- Reset, then idle for 50 cycles -> `tx`=1, `busy`=0, `count`=0, `full`=0, `overflow`=0 throughout.
- CLKS_PER_BIT=4: write 0xA55A -> `tx` falls one cycle later.
  - Each bit lasts 4 cycles.
  - Bit stream: 0, 0,1,0,1,1,0,1,0, 1, 0, 1,0,1,0,0,1,0,1, 1.
  - `busy` is high for exactly 80 cycles.
- DEPTH=4: six consecutive writes 0x0001..0x0006 while idle:
  - Words 1-5 are accepted; word 1 is popped on the edge after its write.
  - `full`=1 after word 5.
  - Word 6 is dropped and `overflow`=1.
  - Transmitted order is 0x0001..0x0005.
  - `overflow` stays 1 after the FIFO drains.
- Write 0x1234, then 0xBEEF 3 cycles later -> both are sent in order; the second start bit begins 20·CLKS_PER_BIT+1 cycles after the first.
- Assert `reset` for 1 cycle during the DATA state of the high byte with 2 words queued:
  - `tx`=1 immediately; `count`=0 and `busy`=0 after reset.
  - A new write of 0x00FF afterwards transmits correctly.
- Pointer wrap: stream 10 words with DEPTH=4, writing each as the previous word completes -> all 10 are received intact and `overflow` stays 0.
